// File: rtl/spi_pwm_array.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pwm_array
//  Purpose  : NUM_CH-channel PWM generator with a mode-0 SPI slave that
//             writes (and optionally reads) double-buffered duty levels and
//             a shared period register. SPI pins are oversampled by clk.
//  Options  : SPI_READBACK_EN - when defined, read commands shift the
//             addressed shadow register out on miso; otherwise miso is 0
//             and read commands are consumed without effect.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_array #(
    parameter int NUM_CH      = 7,
    parameter int PWM_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_wrap
);

    // Shift-in keeps only the bits preceding the one currently on mosi,
    // so it needs 7 bits for a command and PWM_W-1 bits for a data word.
    localparam int               c_sh_w      = (PWM_W > 8) ? PWM_W - 1 : 7;
    localparam logic [3:0]       c_cmd_last  = 4'd7;
    localparam logic [3:0]       c_data_last = 4'(PWM_W - 1);
    localparam logic [6:0]       c_top_addr  = 7'h7F;
    localparam logic [PWM_W-1:0] c_top_rst   = {{(PWM_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   w_sclk_s;
    logic                   w_cs_n_s;
    logic                   w_mosi_s;
    logic                   w_rise;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_cmd_done;
    logic                   w_word_done;
    logic [3:0]             r_bcnt;
    logic [c_sh_w-1:0]      r_shift_in;
    logic                   r_wr;
    logic [6:0]             r_addr;
    logic                   w_cmd_wr;
    logic [6:0]             w_cmd_addr;
    logic [PWM_W-1:0]       w_word;
    logic                   w_top_wr;

    logic [PWM_W-1:0]       r_cnt;
    logic [PWM_W-1:0]       r_top_sh;
    logic [PWM_W-1:0]       r_top_act;
    logic                   r_period_wrap;
    logic                   w_wrap;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk_s & ~r_sclk_prev;

    // The 8th command bit is still on mosi when the command completes
    assign w_cmd_wr   = r_shift_in[6];
    assign w_cmd_addr = {r_shift_in[5:0], w_mosi_s};
    assign w_word     = {r_shift_in[PWM_W-2:0], w_mosi_s};
    assign w_top_wr   = w_word_done & r_wr & (r_addr == c_top_addr);

    // SPI state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SPI next-state and command/word completion strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_done  = 1'b0;
        w_word_done = 1'b0;
        if (w_cs_n_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_CMD;
                S_CMD: begin
                    if (w_rise && (r_bcnt == c_cmd_last)) begin
                        w_cmd_done  = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_rise && (r_bcnt == c_data_last)) begin
                        w_word_done = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Receive shifter, bit counter and burst address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt     <= '0;
            r_shift_in <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
        end else if (w_cs_n_s) begin
            r_bcnt     <= '0;
        end else if (w_rise && (r_state != S_IDLE)) begin
            r_shift_in <= {r_shift_in[c_sh_w-2:0], w_mosi_s};
            if (w_cmd_done) begin
                r_wr   <= w_cmd_wr;
                r_addr <= w_cmd_addr;
                r_bcnt <= '0;
            end else if (w_word_done) begin
                r_addr <= r_addr + 7'd1;
                r_bcnt <= '0;
            end else begin
                r_bcnt <= r_bcnt + 4'd1;
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic             w_fall;
    logic             r_rd_pend;
    logic             r_miso;
    logic [PWM_W-1:0] r_shift_out;
    logic [PWM_W-1:0] w_rd_data;
    logic [PWM_W-1:0] w_lvl_sh [NUM_CH];

    assign w_fall = ~w_sclk_s & r_sclk_prev;

    // Read mux over the shadow registers; unmapped addresses read 0
    always_comb begin
        w_rd_data = '0;
        if (r_addr == c_top_addr) begin
            w_rd_data = r_top_sh;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_addr == 7'(i)) begin
                w_rd_data = w_lvl_sh[i];
            end
        end
    end

    // Transmit shifter: a load is armed at the end of a read command or word
    // and happens on the next falling edge, which also presents the MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend   <= 1'b0;
            r_miso      <= 1'b0;
            r_shift_out <= '0;
        end else if (w_cs_n_s) begin
            r_rd_pend   <= 1'b0;
            r_miso      <= 1'b0;
            r_shift_out <= '0;
        end else begin
            if (w_cmd_done) begin
                r_rd_pend <= ~w_cmd_wr;
            end else if (w_word_done) begin
                r_rd_pend <= ~r_wr;
            end
            if (w_fall && (r_state == S_DATA)) begin
                if (r_rd_pend) begin
                    r_rd_pend   <= 1'b0;
                    r_miso      <= w_rd_data[PWM_W-1];
                    r_shift_out <= {w_rd_data[PWM_W-2:0], 1'b0};
                end else begin
                    r_miso      <= r_shift_out[PWM_W-1];
                    r_shift_out <= {r_shift_out[PWM_W-2:0], 1'b0};
                end
            end
        end
    end

    assign miso = r_miso;
`else
    assign miso = 1'b0;
`endif

    assign w_wrap = (r_cnt == r_top_act);

    // Period counter with double-buffered top register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_top_sh      <= c_top_rst;
            r_top_act     <= c_top_rst;
            r_period_wrap <= 1'b0;
        end else begin
            if (w_top_wr) begin
                r_top_sh <= w_word;
            end
            if (w_wrap) begin
                r_cnt     <= '0;
                r_top_act <= r_top_sh;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_period_wrap <= w_wrap;
        end
    end

    assign period_wrap = r_period_wrap;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PWM_W-1:0] r_lvl_sh;
        logic [PWM_W-1:0] r_lvl_act;
        logic             r_pwm;
        logic             w_wr_en;

        assign w_wr_en = w_word_done & r_wr & (r_addr == 7'(g));

        // Per-channel shadow/active level and registered comparator
        always_ff @(posedge clk) begin
            if (reset) begin
                r_lvl_sh  <= '0;
                r_lvl_act <= '0;
                r_pwm     <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_lvl_sh <= w_word;
                end
                if (w_wrap) begin
                    r_lvl_act <= r_lvl_sh;
                end
                r_pwm <= (r_cnt < r_lvl_act);
            end
        end

        assign pwm_out[g] = r_pwm;
`ifdef SPI_READBACK_EN
        assign w_lvl_sh[g] = r_lvl_sh;
`endif
    end

endmodule
`default_nettype wire
